rsa_job_fifo: RTL and testbench

Parametrised storage buffer for RSA decryption jobs. Each entry is one tuple: modulus n, private key d and ciphertext c. The block sits between the key/cipher loader and the modular-exponentiation core, decoupling them with valid/ready handshakes on both sides. Adds full/empty status, occupancy count, wrap-safe pointers, flush and a sticky overflow flag.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_job_fifo_if.sv | 38 +++
 rtl/rsa_fifo_ctrl.sv | 73 +++++++
 rtl/rsa_job_fifo.sv | 57 +++++
 tb/tb_rsa_job_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
//==== rsa_pkg -- shared job type for the RSA job buffer | rev 1.0 ====
`default_nettype none

package rsa_pkg;

  localparam int RSA_WIDTH = 32;

  typedef struct packed {
    logic [RSA_WIDTH-1:0] n;
    logic [RSA_WIDTH-1:0] d;
    logic [RSA_WIDTH-1:0] c;
  } rsa_job_t;

endpackage

`default_nettype wire

// File: rtl/rsa_job_fifo_if.sv
//==== rsa_job_fifo_if -- loader/core handshake and status bundle | rev 1.0 ====
`default_nettype none

interface rsa_job_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] in_d;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_c;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf_err;

  modport master (
    output flush, in_valid, in_n, in_d, in_c, out_ready,
    input  in_ready, out_valid, out_n, out_d, out_c, count, full, empty, ovf_err
  );

  modport slave (
    input  flush, in_valid, in_n, in_d, in_c, out_ready,
    output in_ready, out_valid, out_n, out_d, out_c, count, full, empty, ovf_err
  );

endinterface

`default_nettype wire

// File: rtl/rsa_fifo_ctrl.sv
//==== rsa_fifo_ctrl -- pointers, occupancy, status and overflow flag | rev 1.0 ====
`default_nettype none

module rsa_fifo_ctrl #(
  parameter  int DEPTH = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_flush,
  input  wire logic          i_push_req,
  input  wire logic          i_pop_req,
  output logic               o_wr_en,
  output logic [PW-1:0]      o_wr_ptr,
  output logic [PW-1:0]      o_rd_ptr,
  output logic [CW-1:0]      o_count,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_ovf_err
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf_err;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push_req && !w_full;
  assign w_pop   = i_pop_req && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      // Explicit wrap so non-power-of-two depths work
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
      if (i_push_req && w_full)
        r_ovf_err <= 1'b1;
    end
  end

  assign o_wr_en   = w_push && !i_flush;
  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_ovf_err = r_ovf_err;

endmodule

`default_nettype wire

// File: rtl/rsa_job_fifo.sv
//==== rsa_job_fifo -- show-ahead FIFO of RSA {n,d,c} decryption jobs | rev 1.0 ====
`default_nettype none

module rsa_job_fifo
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int DEPTH = 32
) (
  input wire logic      clk,
  input wire logic      rst,
  rsa_job_fifo_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsa_job_t      r_mem [DEPTH];
  rsa_job_t      w_head;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;

  rsa_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (bus.flush),
    .i_push_req (bus.in_valid),
    .i_pop_req  (bus.out_ready),
    .o_wr_en    (w_wr_en),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (bus.count),
    .o_full     (bus.full),
    .o_empty    (bus.empty),
    .o_ovf_err  (bus.ovf_err)
  );

  // Storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_ptr] <= '{n: RSA_WIDTH'(bus.in_n),
                           d: RSA_WIDTH'(bus.in_d),
                           c: RSA_WIDTH'(bus.in_c)};
  end

  assign w_head        = r_mem[w_rd_ptr];
  assign bus.in_ready  = !bus.full;
  assign bus.out_valid = !bus.empty;
  assign bus.out_n     = bus.empty ? '0 : WIDTH'(w_head.n);
  assign bus.out_d     = bus.empty ? '0 : WIDTH'(w_head.d);
  assign bus.out_c     = bus.empty ? '0 : WIDTH'(w_head.c);

endmodule

`default_nettype wire

// File: tb/tb_rsa_job_fifo.sv
//==== tb_rsa_job_fifo -- directed, table and random checks of rsa_job_fifo | rev 1.0 ====
`timescale 1ns/1ps

module tb_rsa_job_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 5;

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [31:0] c;
    int          cnt;
    bit          full;
    bit          empty;
    bit          ovf;
    logic [31:0] oc;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3*W-1:0] mq[$];
  bit             m_ovf;
  vec_t           tbl[11];

  rsa_job_fifo_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

  rsa_job_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit full_now;
    bit empty_now;
    if (bus.flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      full_now  = (mq.size() == DEPTH);
      empty_now = (mq.size() == 0);
      if (bus.in_valid && full_now) m_ovf = 1'b1;
      if (bus.out_ready && !empty_now) void'(mq.pop_front());
      if (bus.in_valid && !full_now) mq.push_back({bus.in_n, bus.in_d, bus.in_c});
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3*W-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, " count"},     bus.count,     mq.size());
    chk({tag, " full"},      bus.full,      mq.size() == DEPTH);
    chk({tag, " empty"},     bus.empty,     mq.size() == 0);
    chk({tag, " in_ready"},  bus.in_ready,  mq.size() != DEPTH);
    chk({tag, " out_valid"}, bus.out_valid, mq.size() != 0);
    chk({tag, " out_job"},   {bus.out_n, bus.out_d, bus.out_c}, head);
    chk({tag, " ovf_err"},   bus.ovf_err,   m_ovf);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl, input logic [31:0] n,
                       input logic [31:0] d, input logic [31:0] c);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.in_n      = n;
    bus.in_d      = d;
    bus.in_c      = c;
  endtask

  initial begin
    tbl = '{
      '{1, 0, 32'd1, 1, 0, 0, 0, 32'd1},
      '{1, 0, 32'd2, 2, 0, 0, 0, 32'd1},
      '{1, 0, 32'd3, 3, 0, 0, 0, 32'd1},
      '{1, 0, 32'd4, 4, 0, 0, 0, 32'd1},
      '{1, 0, 32'd5, 5, 1, 0, 0, 32'd1},
      '{1, 0, 32'd6, 5, 1, 0, 1, 32'd1},
      '{0, 1, 32'd0, 4, 0, 0, 1, 32'd2},
      '{0, 1, 32'd0, 3, 0, 0, 1, 32'd3},
      '{0, 1, 32'd0, 2, 0, 0, 1, 32'd4},
      '{0, 1, 32'd0, 1, 0, 0, 1, 32'd5},
      '{0, 1, 32'd0, 0, 0, 1, 1, 32'd0}
    };
    m_ovf = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count",     bus.count, 0);
    chk("reset empty",     bus.empty, 1);
    chk("reset full",      bus.full, 0);
    chk("reset in_ready",  bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_c",     bus.out_c, 0);
    chk("reset ovf",       bus.ovf_err, 0);
    rst = 1'b0;

    // First push appears on the next cycle
    drive(1, 0, 0, 32'h11, 32'h22, 32'h33);
    cycle("t1");
    chk("t1 out_valid", bus.out_valid, 1);
    chk("t1 out_job", {bus.out_n, bus.out_d, bus.out_c}, {32'h11, 32'h22, 32'h33});
    chk("t1 count", bus.count, 1);
    drive(0, 1, 0, 0, 0, 0);
    cycle("t1 pop");
    chk("t1 empty", bus.empty, 1);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, 0, tbl[i].c + 100, tbl[i].c + 200, tbl[i].c);
      cycle("t2");
      chk($sformatf("t2[%0d] count", i), bus.count, tbl[i].cnt);
      chk($sformatf("t2[%0d] full", i), bus.full, tbl[i].full);
      chk($sformatf("t2[%0d] in_ready", i), bus.in_ready, !tbl[i].full);
      chk($sformatf("t2[%0d] empty", i), bus.empty, tbl[i].empty);
      chk($sformatf("t2[%0d] ovf", i), bus.ovf_err, tbl[i].ovf);
      chk($sformatf("t2[%0d] out_c", i), bus.out_c, tbl[i].oc);
    end

    drive(0, 0, 1, 0, 0, 0);
    cycle("clr");
    chk("clr ovf", bus.ovf_err, 0);

    // Empty with both valid and ready: push only
    drive(1, 1, 0, 32'd110, 32'd210, 32'd10);
    cycle("t3 fill");
    chk("t3 empty push count", bus.count, 1);
    for (int k = 11; k <= 12; k++) begin
      drive(1, 0, 0, k + 100, k + 200, k);
      cycle("t3 fill");
    end
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 113 + k, 213 + k, 13 + k);
      cycle("t3 stream");
      chk($sformatf("t3[%0d] count", k), bus.count, 3);
      chk($sformatf("t3[%0d] out_c", k), bus.out_c, 11 + k);
    end

    for (int k = 23; k <= 24; k++) begin
      drive(1, 0, 0, k + 100, k + 200, k);
      cycle("t4 fill");
    end
    chk("t4 full", bus.full, 1);
    drive(1, 1, 0, 125, 225, 25);
    cycle("t4");
    chk("t4 count", bus.count, DEPTH - 1);
    chk("t4 in_ready", bus.in_ready, 1);
    chk("t4 ovf", bus.ovf_err, 1);
    chk("t4 out_c", bus.out_c, 21);

    drive(1, 1, 1, 199, 299, 99);
    cycle("t5");
    chk("t5 count", bus.count, 0);
    chk("t5 empty", bus.empty, 1);
    chk("t5 ovf", bus.ovf_err, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle("t5 idle");
    chk("t5 not stored", bus.out_valid, 0);

    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 32'h140 + k, 32'h240 + k, 32'h40 + k);
      cycle("t6 fill");
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    chk("t6 async count", bus.count, 0);
    chk("t6 async empty", bus.empty, 1);
    chk("t6 async out_valid", bus.out_valid, 0);
    chk("t6 async out_c", bus.out_c, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("t6 rel");
    drive(1, 0, 0, 32'h55, 32'h66, 32'h77);
    cycle("t6 push");
    chk("t6 readback", {bus.out_n, bus.out_d, bus.out_c}, {32'h55, 32'h66, 32'h77});
    chk("t6 count", bus.count, 1);

    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
            $urandom, $urandom, $urandom);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
